// File: rtl/board_io_conditioner.sv
// board_io_conditioner: synchronises board pins, debounces switches and turns interrupt pins into level/edge irqs
module board_io_conditioner #(
  parameter int N_SW = 2,
  parameter int N_EXT = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter logic [2*N_EXT-1:0] EXT_MODE = {N_EXT{2'b01}},
  parameter int PULSE_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_SW-1:0]  sw_changed,
  input  logic [N_EXT-1:0] ext_raw,
  output logic [N_EXT-1:0] ext_irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  logic [SYNC_STAGES-1:0][N_SW-1:0]  sw_sync;
  logic [SYNC_STAGES-1:0][N_EXT-1:0] ext_sync;
  logic [N_SW-1:0]  sw_s;
  logic [N_EXT-1:0] ext_s, ext_prev, ext_ev;
  logic [CW-1:0]    sw_cnt [N_SW];
  logic [PW-1:0]    pulse_cnt [N_EXT];
  logic [PW-1:0]    pulse_nxt [N_EXT];
  logic [AW-1:0]    arm_cnt;
  logic             armed;
  assign sw_s  = sw_sync[SYNC_STAGES-1];
  assign ext_s = ext_sync[SYNC_STAGES-1];
  assign armed = arm_cnt == AW'(SYNC_STAGES + 1);
  always_ff @(posedge clock)
    if (reset) begin
      sw_sync  <= '0;
      ext_sync <= '0;
      arm_cnt  <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], sw_raw};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_raw};
      arm_cnt  <= armed ? arm_cnt : arm_cnt + AW'(1);
    end
  always_ff @(posedge clock)
    for (int i = 0; i < N_SW; i++)
      if (reset) begin
        sw_cnt[i]     <= '0;
        sw_clean[i]   <= 1'b0;
        sw_changed[i] <= 1'b0;
      end else if (sw_s[i] == sw_clean[i]) begin
        sw_cnt[i]     <= '0;
        sw_changed[i] <= 1'b0;
      end else if (sw_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        sw_cnt[i]     <= '0;
        sw_clean[i]   <= sw_s[i];
        sw_changed[i] <= 1'b1;
      end else begin
        sw_cnt[i]     <= sw_cnt[i] + CW'(1);
        sw_changed[i] <= 1'b0;
      end
  // events are masked until the synchroniser and prev have settled after reset
  always_comb
    for (int i = 0; i < N_EXT; i++) begin
      ext_ev[i]    = armed && (EXT_MODE[2*i +: 2] == 2'b01 ? ext_s[i] & ~ext_prev[i] :
                               EXT_MODE[2*i +: 2] == 2'b10 ? ~ext_s[i] & ext_prev[i] :
                               EXT_MODE[2*i +: 2] == 2'b11 ? ext_s[i] ^ ext_prev[i] : 1'b0);
      pulse_nxt[i] = ext_ev[i] ? PW'(PULSE_CYCLES) :
                     pulse_cnt[i] != '0 ? pulse_cnt[i] - PW'(1) : '0;
    end
  always_ff @(posedge clock)
    for (int i = 0; i < N_EXT; i++)
      if (reset) begin
        ext_prev[i]  <= 1'b0;
        pulse_cnt[i] <= '0;
        ext_irq[i]   <= 1'b0;
      end else begin
        ext_prev[i]  <= ext_s[i];
        pulse_cnt[i] <= pulse_nxt[i];
        ext_irq[i]   <= EXT_MODE[2*i +: 2] == 2'b00 ? ext_s[i] : pulse_nxt[i] != '0;
      end
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: directed stimulus queues expected output changes; a monitor pops them as outputs change
module tb_board_io_conditioner;
  typedef struct {
    int          cyc;
    logic [10:0] val;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sw_raw, sw_clean, sw_changed;
  logic [3:0]  ext_raw, ext_irq;
  logic        sw5, sw_clean5, sw_changed5, ext5, irq5;
  logic [10:0] snap, prev;
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          c;
  exp_t        q[$];
  board_io_conditioner #(
    .N_SW(2), .N_EXT(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .EXT_MODE(8'b00_11_10_01), .PULSE_CYCLES(3)
  ) dut (
    .clock(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean),
    .sw_changed(sw_changed), .ext_raw(ext_raw), .ext_irq(ext_irq)
  );
  board_io_conditioner #(
    .N_SW(1), .N_EXT(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .EXT_MODE(2'b01), .PULSE_CYCLES(5)
  ) dut5 (
    .clock(clk), .reset(reset), .sw_raw(sw5), .sw_clean(sw_clean5),
    .sw_changed(sw_changed5), .ext_raw(ext5), .ext_irq(irq5)
  );
  assign snap = {irq5, sw_clean5, sw_changed5, ext_irq, sw_changed, sw_clean};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [10:0] mk(logic i5, logic [3:0] irq, logic [1:0] chg, logic [1:0] cl);
    return {i5, 1'b0, 1'b0, irq, chg, cl};
  endfunction
  task automatic push(int at, logic [10:0] v);
    q.push_back('{cyc: at, val: v});
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en && snap !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %h at cycle %0d, expected no change", snap, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.val !== snap) begin
          fails++;
          $display("FAIL output_change: got %h at cycle %0d, expected %h at cycle %0d", snap, cyc, e.val, e.cyc);
        end
      end
    end
    prev = snap;
  end
  initial begin
    reset = 1'b1; sw_raw = 2'b01; ext_raw = 4'b0001; ext5 = 1'b1; sw5 = 1'b0;
    step(3);
    check("reset_state", snap, 11'h0);
    mon_en = 1'b1;
    reset = 1'b0; c = cyc;
    push(c + 6, mk(1'b0, 4'h0, 2'b01, 2'b01));
    push(c + 7, mk(1'b0, 4'h0, 2'b00, 2'b01));
    step(12);
    check("arm_no_irq", snap, mk(1'b0, 4'h0, 2'b00, 2'b01));
    sw_raw = 2'b00; ext_raw = 4'h0; ext5 = 1'b0; c = cyc;
    push(c + 6, mk(1'b0, 4'h0, 2'b01, 2'b00));
    push(c + 7, 11'h0);
    step(10);
    sw_raw[0] = 1'b1; c = cyc;
    push(c + 6, mk(1'b0, 4'h0, 2'b01, 2'b01));
    push(c + 7, mk(1'b0, 4'h0, 2'b00, 2'b01));
    step(10);
    repeat (5) begin
      sw_raw[1] = 1'b1; step(3);
      sw_raw[1] = 1'b0; step(3);
    end
    step(6);
    check("glitch_reject", snap, mk(1'b0, 4'h0, 2'b00, 2'b01));
    ext_raw[2:0] = 3'b111; c = cyc;
    push(c + 3,  mk(1'b0, 4'b0101, 2'b00, 2'b01));
    push(c + 6,  mk(1'b0, 4'b0000, 2'b00, 2'b01));
    push(c + 13, mk(1'b0, 4'b0110, 2'b00, 2'b01));
    push(c + 16, mk(1'b0, 4'b0000, 2'b00, 2'b01));
    step(10);
    ext_raw[2:0] = 3'b000;
    step(10);
    ext_raw[3] = 1'b1; c = cyc;
    push(c + 3, mk(1'b0, 4'b1000, 2'b00, 2'b01));
    push(c + 7, mk(1'b0, 4'b0000, 2'b00, 2'b01));
    step(4);
    ext_raw[3] = 1'b0;
    step(8);
    ext5 = 1'b1; c = cyc;
    push(c + 3,  mk(1'b1, 4'h0, 2'b00, 2'b01));
    push(c + 10, mk(1'b0, 4'h0, 2'b00, 2'b01));
    step(1); ext5 = 1'b0;
    step(1); ext5 = 1'b1;
    step(3); ext5 = 1'b0;
    step(10);
    sw_raw[1] = 1'b1; ext_raw[0] = 1'b1; c = cyc;
    push(c + 3, mk(1'b0, 4'b0001, 2'b00, 2'b01));
    push(c + 5, 11'h0);
    step(4);
    reset = 1'b1; sw_raw = 2'b00;
    step(2);
    reset = 1'b0;
    step(15);
    check("post_reset_quiet", snap, 11'h0);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d unmatched, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
